// File: rtl/spi_pkg.sv
// Shared constants for the SPI target port: byte width, synchronizer depth,
// SPI mode encoding and the stream terminator byte.
package spi_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [BYTE_W-1:0] NULL_BYTE = '0;

  // Encoded as {CPOL, CPHA}.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  localparam spi_mode_e SPI_MODE = SPI_MODE0;

  function automatic logic mode_cpol(input spi_mode_e mode);
    return mode[1];
  endfunction

  // Level SCLK rests at between transfers.
  localparam logic SCLK_IDLE = mode_cpol(SPI_MODE);

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive byte FIFO: circular buffer with one extra pointer bit to tell
// full from empty, and a registered head-of-queue output.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic [BYTE_W-1:0] head_data,
  output logic              head_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [BYTE_W-1:0] head_data_q, head_data_d;
  logic              head_valid_q, head_valid_d;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer/storage update and head register next state.
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    // Head tracks the post-pop read pointer against the pre-push write
    // pointer: pops take effect immediately, a new byte shows one cycle
    // after it has been written.
    head_valid_d = (wr_ptr_q != rd_ptr_d);
    head_data_d  = mem_q[rd_ptr_d[AW-1:0]];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_data_q  <= '0;
      head_valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_data_q  <= head_data_d;
      head_valid_q <= head_valid_d;
      mem_q        <= mem_d;
    end
  end

  assign head_data  = head_data_q;
  assign head_valid = head_valid_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 target: oversamples SCLK/SS/MOSI on cpu_clk, assembles
// MSB-first bytes into the RX FIFO and shifts reply bytes out on MISO.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [BYTE_W-1:0] IDLE_BYTE  = 8'h00
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_null,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              overflow,
  output logic              underrun,
  input  logic              clr_flags
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic                   active_q, active_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]      tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]      hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   byte_done_q, byte_done_d;
  logic                   underrun_q, underrun_d;
  logic                   overflow_q, overflow_d;
  logic                   tx_load;
  logic                   pop;
  logic                   fifo_full;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;

  // Synchronizer chains plus one history stage for edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  // Select handling, bit counter and the RX/TX shift registers.
  always_comb begin
    active_d    = active_q;
    miso_oe_d   = miso_oe_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    byte_done_d = 1'b0;
    tx_load     = 1'b0;
    if (ss_fall) begin
      active_d  = 1'b1;
      miso_oe_d = 1'b1;
      bit_cnt_d = '0;
      tx_load   = 1'b1;
    end else if (ss_rise) begin
      active_d  = 1'b0;
      miso_oe_d = 1'b0;
      bit_cnt_d = '0;
    end else if (active_q && !ss_s) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_d = 1'b1;
          tx_load     = 1'b1;
        end
      end else if (sclk_fall && (bit_cnt_q != '0)) begin
        // The fall right after a byte boundary must keep the freshly
        // loaded MSB on the line, hence no shift when the count is zero.
        tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
      end
    end
    if (tx_load) begin
      tx_shift_d = hold_full_q ? hold_q : IDLE_BYTE;
    end
  end

  // TX holding register and underrun pulse.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    if (tx_load) begin
      if (hold_full_q) begin
        hold_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign pop = rx_valid && rx_ready;

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_comb begin
    overflow_d = (overflow_q && !clr_flags) || (byte_done_q && fifo_full && !pop);
  end

  // State registers; synchronizers preset to the idle bus levels.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q   <= 1'b1;
      active_q    <= 1'b0;
      miso_oe_q   <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      byte_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      active_q    <= active_d;
      miso_oe_q   <= miso_oe_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      byte_done_q <= byte_done_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
    end
  end

  spi_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (cpu_clk),
    .rst_n     (rst_n),
    .push      (byte_done_q),
    .push_data (rx_shift_q),
    .pop       (pop),
    .full      (fifo_full),
    .head_data (rx_data),
    .head_valid(rx_valid)
  );

  assign miso     = miso_oe_q & tx_shift_q[BYTE_W-1];
  assign miso_oe  = miso_oe_q;
  assign rx_null  = byte_done_q & (rx_shift_q == NULL_BYTE);
  assign tx_ready = ~hold_full_q;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
SPI mode-0 responder (target) for the SOC's SPI master pins (spi_clk_o, spi_ss, spi_mosi, spi_miso). It oversamples the master's SCLK/SS/MOSI on the system clock and assembles MSB-first bytes into a small RX FIFO. In the same transfers it shifts reply bytes out on MISO. It is the on-chip or board-side counterpart used to receive the SOC's character stream and flag the 0x00 terminator.

Parameters:
FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2.
IDLE_BYTE, 8'h00, byte shifted out on MISO when no TX byte is pending.

Ports:
cpu_clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock from master; asynchronous; idle low.
ss_n  input  1  slave select from master; asynchronous; active low.
mosi  input  1  master-out data; asynchronous.
miso  output  1  slave-out data.
miso_oe  output  1  MISO drive enable; high only while synchronized ss_n is low.
rx_data  output  8  head of RX FIFO.
rx_valid  output  1  RX FIFO non-empty.
rx_ready  input  1  consumer pops head when rx_valid && rx_ready.
rx_null  output  1  one-cycle pulse when a completed byte equals 8'h00.
tx_data  input  8  reply byte.
tx_valid  input  1  reply byte offered.
tx_ready  output  1  TX holding register empty.
overflow  output  1  sticky; a byte was dropped because the FIFO was full.
underrun  output  1  one-cycle pulse when IDLE_BYTE is loaded because no TX byte was pending.
clr_flags  input  1  synchronous clear of overflow.

Behaviour:
- Reset: miso=0, miso_oe=0, rx_valid=0, rx_data=0, rx_null=0, tx_ready=1, overflow=0, underrun=0; FIFO empty; bit counter=0; all synchronizers preset to idle (sclk=0, ss_n=1, mosi=0).
- Sync: sclk, ss_n and mosi each pass through a 2-FF synchronizer. A third register on sclk gives rise and fall detection. Requires SCLK period ≥ 6 cpu_clk periods.
- Bit timing is mode 0 (CPOL=0, CPHA=0):
  - On a detected SCLK rise with ss_n low, shift the synchronized mosi into the LSB of rx_shift and increment the 3-bit counter.
  - On a detected SCLK fall, shift tx_shift left and present the new MSB on miso.
- Select handling:
  - On the ss_n falling edge, bit counter=0, load tx_shift, and drive miso = its MSB.
  - On an ss_n rise, abort the byte in progress: discard the partial byte, counter=0, miso_oe=0. A byte that has already completed is kept.
- Byte complete: occurs on the rise where the counter wraps 7→0. The full byte is written to the FIFO on the next cycle. rx_valid rises 4 cpu_clk edges after the first edge that samples sclk high at the pin. rx_null pulses in the same cycle as the FIFO write if the byte is 0x00; the byte is also stored.
- TX load:
  - tx_shift reloads at the ss_n fall and on each byte-complete, for back-to-back bytes.
  - If the holding register is full, load it and set tx_ready=1.
  - If it is empty, load IDLE_BYTE and pulse underrun.
  - tx_valid && tx_ready fills the holding register on the next edge; tx_ready then drops.
- FIFO:
  - Circular buffer with pointers one bit wider than log2(FIFO_DEPTH), wrapping at depth.
  - A push when full and not popping in the same cycle: byte dropped, overflow set.
  - A push and a pop in the same cycle while full: both succeed, count is unchanged.
  - Pop when empty: ignored.
  - rx_data always shows the head entry, registered.
- overflow: clr_flags clears it. If a clear and a new overflow happen in the same cycle, overflow stays set.
- Reset mid-transfer: immediate return to the reset state; the next byte starts only on a fresh ss_n fall.

Decomposition:
- Package spi_pkg: BYTE_W=8, SYNC_STAGES=2, the mode-0 enum/constants, and the null byte constant.
- One sub-module: spi_rx_fifo, the parameterised synchronous FIFO with push/pop/full/empty.
- Synchronizers and the shift engine stay in the top level.

Test Plan:
- Reset, then the master sends 0x48, 0x69 with SCLK = cpu_clk/8 -> rx_data 0x48 then 0x69 popped in order; rx_valid latency 4 cycles per byte; no rx_null.
- Load tx_data=0xA5 before the ss_n fall, master clocks one byte -> the master samples MISO bits 1,0,1,0,0,1,0,1; tx_ready returns to 1 at the ss_n fall.
- Two back-to-back bytes with no TX byte offered -> MISO sends 0x00 0x00 and underrun pulses twice.
- Master sends 0x00 -> rx_null pulses once; rx_data=0x00 is stored.
- rx_ready=0, master sends FIFO_DEPTH+1 bytes (0x01..0x05) -> first 4 retained, 0x05 dropped, overflow=1; clr_flags -> overflow=0.
- ss_n raised after 5 bits, then a full byte 0x3C -> only 0x3C appears. Separately, assert rst_n low mid-byte -> all outputs return to reset values and the FIFO is empty.
